// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - Clause-22 MDIO master, one read/write frame per request.
// Build option: MDIO_PREAMBLE_SUPPRESS_EN drops the 32-bit preamble.
module mdio_master #(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phy,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);
    localparam logic [2:0] IDLE = 3'd0, PRE = 3'd1, HDR = 3'd2, TA = 3'd3,
                           DATA = 3'd4, TAIL = 3'd5, DONE = 3'd6;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic [2:0] FIRST = HDR;
`else
    localparam logic [2:0] FIRST = PRE;
`endif
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);

    logic [2:0]       state_q, state_d, nxt_state;
    logic [4:0]       cnt_q, cnt_d, nxt_cnt;
    logic [DIV_W-1:0] div_q, div_d;
    logic             load_q, load_d;
    logic             mdc_q, mdc_d, mdio_o_q, mdio_o_d, mdio_oe_q, mdio_oe_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [15:0]      rsp_rdata_q, rsp_rdata_d;
    logic             wr_q, wr_d, ta_q, ta_d;
    logic [4:0]       phy_q, phy_d, reg_q, reg_d;
    logic [15:0]      wdata_q, wdata_d, shift_q, shift_d;
    logic [13:0]      hdr;

    function automatic logic [4:0] state_last(input logic [2:0] st);
        case (st)
            PRE:     state_last = 5'd31;
            HDR:     state_last = 5'd13;
            TA:      state_last = 5'd1;
            DATA:    state_last = 5'd15;
            default: state_last = 5'd0;
        endcase
    endfunction

    function automatic logic [2:0] state_next(input logic [2:0] st);
        case (st)
            PRE:     state_next = HDR;
            HDR:     state_next = TA;
            TA:      state_next = DATA;
            DATA:    state_next = TAIL;
            default: state_next = DONE;
        endcase
    endfunction

    // Returns {oe, o} for bit cnt of frame section st.
    function automatic logic [1:0] frame_bit(input logic [2:0] st, input logic [4:0] cnt,
                                             input logic wr, input logic [13:0] h,
                                             input logic [15:0] wd);
        case (st)
            PRE:     frame_bit = 2'b11;
            HDR:     frame_bit = {1'b1, h[4'd13 - cnt[3:0]]};
            TA:      frame_bit = wr ? {1'b1, cnt == 5'd0} : 2'b01;
            DATA:    frame_bit = wr ? {1'b1, wd[4'd15 - cnt[3:0]]} : 2'b01;
            default: frame_bit = 2'b01;
        endcase
    endfunction

    assign hdr       = {2'b01, wr_q ? 2'b01 : 2'b10, phy_q, reg_q};
    assign req_ready = (state_q == IDLE) && enable && rstn;
    assign busy      = (state_q != IDLE);
    assign mdc       = mdc_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        if (cnt_q == state_last(state_q)) begin
            nxt_state = state_next(state_q);
            nxt_cnt   = 5'd0;
        end else begin
            nxt_state = state_q;
            nxt_cnt   = cnt_q + 5'd1;
        end
    end

    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;  div_d = div_q;  load_d = load_q;
        mdc_d = mdc_q;  mdio_o_d = mdio_o_q;  mdio_oe_d = mdio_oe_q;
        rsp_valid_d = 1'b0;  rsp_rdata_d = rsp_rdata_q;  rsp_err_d = rsp_err_q;
        wr_d = wr_q;  phy_d = phy_q;  reg_d = reg_q;  wdata_d = wdata_q;
        shift_d = shift_q;  ta_d = ta_q;
        if (!enable) begin
            state_d = IDLE;  mdc_d = 1'b0;  mdio_oe_d = 1'b0;  mdio_o_d = 1'b1;
            div_d = '0;  load_d = 1'b0;  cnt_d = 5'd0;
        end else begin
            case (state_q)
                IDLE: if (req_valid && req_ready) begin
                    wr_d = req_write;  phy_d = req_phy;  reg_d = req_reg;  wdata_d = req_wdata;
                    state_d = FIRST;  cnt_d = 5'd0;  div_d = '0;  load_d = 1'b1;
                end
                DONE: state_d = IDLE;
                default: begin
                    // The cycle after accept only loads the first bit, so bit k starts at accept+1+2*CLK_DIV*k.
                    if (load_q) begin
                        {mdio_oe_d, mdio_o_d} = frame_bit(state_q, cnt_q, wr_q, hdr, wdata_q);
                        mdc_d = 1'b0;  div_d = '0;  load_d = 1'b0;
                    end else if (div_q == DIV_MID) begin
                        mdc_d = 1'b1;
                        div_d = div_q + 1'b1;
                        if (state_q == TA && cnt_q == 5'd1) ta_d = mdio_i;
                        if (state_q == DATA) shift_d = {shift_q[14:0], mdio_i};
                    end else if (div_q == DIV_LAST) begin
                        mdc_d = 1'b0;  div_d = '0;
                        state_d = nxt_state;  cnt_d = nxt_cnt;
                        if (nxt_state == DONE) begin
                            mdio_oe_d = 1'b0;  mdio_o_d = 1'b1;  rsp_valid_d = 1'b1;
                            rsp_rdata_d = wr_q ? 16'h0000 : shift_q;
                            rsp_err_d   = wr_q ? 1'b0 : ta_q;
                        end else begin
                            {mdio_oe_d, mdio_o_d} = frame_bit(nxt_state, nxt_cnt, wr_q, hdr, wdata_q);
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;  cnt_q <= 5'd0;  div_q <= '0;  load_q <= 1'b0;
            mdc_q <= 1'b0;  mdio_o_q <= 1'b1;  mdio_oe_q <= 1'b0;
            rsp_valid_q <= 1'b0;  rsp_rdata_q <= 16'h0000;  rsp_err_q <= 1'b0;
            wr_q <= 1'b0;  phy_q <= 5'd0;  reg_q <= 5'd0;  wdata_q <= 16'h0000;
            shift_q <= 16'h0000;  ta_q <= 1'b0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  div_q <= div_d;  load_q <= load_d;
            mdc_q <= mdc_d;  mdio_o_q <= mdio_o_d;  mdio_oe_q <= mdio_oe_d;
            rsp_valid_q <= rsp_valid_d;  rsp_rdata_q <= rsp_rdata_d;  rsp_err_q <= rsp_err_d;
            wr_q <= wr_d;  phy_q <= phy_d;  reg_q <= reg_d;  wdata_q <= wdata_d;
            shift_q <= shift_d;  ta_q <= ta_d;
        end
    end
endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - directed vector bench for mdio_master with a PHY model on mdio_i.
module tb_mdio_master;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam int CD = 2;
    localparam int PREN = 0;
`else
    localparam int CD = 4;
    localparam int PREN = 32;
`endif
    localparam int NB  = PREN + 33;
    localparam int LAT = 1 + 2 * CD * NB;

    logic clk = 1'b0, rstn, enable, req_valid, req_ready, req_write;
    logic [4:0] req_phy, req_reg;
    logic [15:0] req_wdata, rsp_rdata;
    logic rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_oe, mdio_i;

    int n_cmp = 0, n_bad = 0;
    logic [15:0] prev_rdata = 16'h0000;
    logic        prev_err = 1'b0;

    typedef struct packed {
        logic        wr;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wd;
        logic        ta;
        logic [15:0] rd;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[6];

    mdio_master #(.CLK_DIV(CD)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic phy_bit(input vec_t v, input int b);
        int f = b - PREN;
        if (v.wr) return 1'b1;
        if (f == 15) return v.ta;
        if (f >= 16 && f <= 31) return v.rd[31 - f];
        return 1'b1;
    endfunction

    task automatic issue(input vec_t v, input bit hold);
        int w = 0;
        @(negedge clk);
        req_write = v.wr;  req_phy = v.phy;  req_reg = v.rg;  req_wdata = v.wd;  req_valid = 1'b1;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // k = 0 is the cycle that begins at the accept edge.
    task automatic monitor(input vec_t v);
        logic [64:0] eo, eoe, go, goe, mask;
        int lat, b, ph, f, mdc_bad, stab_bad, busy_bad, rdy_bad;
        eo = '0;  eoe = '0;  go = '0;  goe = '0;
        lat = -1;  mdc_bad = 0;  stab_bad = 0;  busy_bad = 0;  rdy_bad = 0;
        for (int i = 0; i < NB; i++) begin
            f = i - PREN;
            eoe[i] = 1'b1;
            if (f < 0)        eo[i] = 1'b1;
            else if (f < 2)   eo[i] = (f == 1);
            else if (f < 4)   eo[i] = v.wr ? (f == 3) : (f == 2);
            else if (f < 9)   eo[i] = v.phy[8 - f];
            else if (f < 14)  eo[i] = v.rg[13 - f];
            else if (f < 16)  begin eoe[i] = v.wr; eo[i] = v.wr ? (f == 14) : 1'b1; end
            else if (f < 32)  begin eoe[i] = v.wr; eo[i] = v.wr ? v.wd[31 - f] : 1'b1; end
            else              begin eoe[i] = 1'b0; eo[i] = 1'b1; end
        end
        mask = eoe;
        mask[NB-1] = 1'b1;
        for (int k = 0; k <= LAT + 4; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
            if (!busy) busy_bad++;
            if (req_ready) rdy_bad++;
            if (k >= 1 && k <= 2 * CD * NB) begin
                b = (k - 1) / (2 * CD);
                ph = (k - 1) % (2 * CD);
                if (mdc !== (ph >= CD)) mdc_bad++;
                if (ph == 0) begin
                    go[b] = mdio_o;
                    goe[b] = mdio_oe;
                end else if (mdio_o !== go[b] || mdio_oe !== goe[b]) begin
                    stab_bad++;
                end
                mdio_i = phy_bit(v, b);
            end else begin
                mdio_i = 1'b1;
            end
        end
        mdio_i = 1'b1;
        check("latency", lat, LAT);
        check("stream_oe", {31'd0, goe != eoe}, 32'd0);
        check("stream_o", {31'd0, (go & mask) != (eo & mask)}, 32'd0);
        check("mdc_pattern", mdc_bad, 0);
        check("mdio_stable_in_bit", stab_bad, 0);
        check("busy_and_not_ready", busy_bad + rdy_bad, 0);
        check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, v.exp_rdata});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
        check("done_lines", {29'd0, mdc, mdio_oe, busy}, 32'd1);
        prev_rdata = v.exp_rdata;
        prev_err = v.exp_err;
        @(negedge clk);
        check("after_done", {28'd0, rsp_valid, busy, req_ready, mdc}, 32'b0010);
    endtask

    initial begin
        //          wr    phy    reg    wdata     ta    phy data  rdata     err
        vecs[0] = '{1'b1, 5'h01, 5'h00, 16'h8000, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 5'h01, 5'h02, 16'h0000, 1'b0, 16'h0141, 16'h0141, 1'b0};
        vecs[2] = '{1'b1, 5'h1F, 5'h1F, 16'hA5C3, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{1'b0, 5'h03, 5'h11, 16'h1234, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1};
        vecs[4] = '{1'b1, 5'h0A, 5'h15, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{1'b0, 5'h12, 5'h07, 16'h0000, 1'b0, 16'h8001, 16'h8001, 1'b0};

        rstn = 1'b0;  enable = 1'b0;  mdio_i = 1'b1;  req_valid = 1'b0;
        req_write = 1'b0;  req_phy = 5'd0;  req_reg = 5'd0;  req_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_lines", {26'd0, mdc, mdio_o, mdio_oe, rsp_valid, busy, req_ready}, 32'b010000);
        check("reset_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("reset_err", {31'd0, rsp_err}, 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("ready_in_reset", {31'd0, req_ready}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i], 1'b0);
            monitor(vecs[i]);
        end

        // enable dropped ten bits into a write
        issue(vecs[2], 1'b0);
        for (int k = 0; k < 2 * CD * 10 + 3; k++) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_lines", {26'd0, mdc, mdio_oe, mdio_o, busy, rsp_valid, req_ready}, 32'b001000);
        check("abort_keeps_rdata", {16'd0, rsp_rdata}, {16'd0, prev_rdata});
        check("abort_keeps_err", {31'd0, rsp_err}, {31'd0, prev_err});
        begin
            int rv = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (rsp_valid || busy || mdc) rv++;
            end
            check("abort_stays_idle", rv, 0);
        end
        enable = 1'b1;
        issue(vecs[1], 1'b0);
        monitor(vecs[1]);

        // reset mid-frame
        issue(vecs[3], 1'b0);
        repeat (40) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midreset_lines", {27'd0, mdc, mdio_oe, mdio_o, busy, rsp_valid}, 32'b00100);
        check("midreset_rdata", {16'd0, rsp_rdata}, 32'd0);
        rstn = 1'b1;
        mdio_i = 1'b1;

        // request held through a frame with new fields
        issue(vecs[0], 1'b1);
        req_write = vecs[5].wr;  req_phy = vecs[5].phy;  req_reg = vecs[5].rg;  req_wdata = vecs[5].wd;
        monitor(vecs[0]);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        monitor(vecs[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
